ex_pipe_ctrl: RTL and testbench
===============================

// Module: ex_pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the EX stage of the RV32IC core. Drives the forwarding muxes at
//  the ALU A/B operands and the stall, bubble and flush controls for IF/ID/EX. Redirects
//  fetch on jumps and taken branches. Holds the pipeline while an ID-stage instruction
//  occupies an external multi-cycle unit.
// PARAMETERS
//  REDIRECT_CYC  2   cycles o_kill_if stays high after a redirect (legal range 1..15)
//  MC_TIMEOUT    64  MCWAIT cycles allowed before giving up (legal range 2..255)
// PORTS
//  i_clk           in   1   clock, all state updates on posedge
//  i_reset         in   1   reset, synchronous, active-high
//  i_id_valid      in   1   ID holds a valid instruction
//  i_id_rs1/rs2    in   5   ID source register indices
//  i_id_use_rs1/2  in   1   ID instruction actually reads rs1 / rs2
//  i_id_mc         in   1   ID instruction needs the multi-cycle unit
//  i_ex_valid      in   1   EX holds a valid instruction
//  i_ex_rd         in   5   EX destination register
//  i_ex_memread    in   1   EX instruction is a load
//  i_jmp           in   1   EX jump/taken-branch indication from the ALU
//  i_jmp_pc        in   32  EX jump target
//  i_mem_rd/wb_rd  in   5   MEM / WB destination registers
//  i_mem_regwrite  in   1   MEM instruction writes rd
//  i_wb_regwrite   in   1   WB instruction writes rd
//  i_mc_done       in   1   multi-cycle unit result ready, 1-cycle pulse
//  o_fwd_a/o_fwd_b out  2   operand source: 0=regfile, 1=MEM ALUOutput, 2=WB data
//  o_stall         out  1   hold PC and IF/ID register
//  o_bubble_ex     out  1   load NOP (all controls 0) into EX register
//  o_flush_id      out  1   invalidate IF/ID register
//  o_pc_load       out  1   load PC with o_pc_target
//  o_pc_target     out  32  redirect address
//  o_kill_if       out  1   discard the fetch response arriving this cycle
//  o_mc_start      out  1   start the multi-cycle unit, 1-cycle pulse
//  o_mc_err        out  1   sticky timeout flag
//  o_state         out  2   FSM state: 0=RUN, 1=REDIR, 2=MCWAIT
// BEHAVIOUR
//  Forwarding (combinational, in every state)
//   - fwd_a=1 if i_mem_regwrite && i_mem_rd!=0 && i_mem_rd==i_id_rs1.
//   - Else fwd_a=2 if the same test passes on the WB fields. Else fwd_a=0. fwd_b uses rs2.
//   - MEM has priority over WB. Register x0 never forwards.
//  FSM and priority: redirect > multi-cycle > load-use. State encoding 3 decodes as RUN.
//   RUN
//    - Redirect condition: i_ex_valid && i_jmp.
//      pc_load=1, pc_target=i_jmp_pc, flush_id=1, bubble_ex=1 (all in the same cycle).
//      Next state REDIR, cnt<=REDIRECT_CYC-1.
//    - Multi-cycle condition: i_id_valid && i_id_mc && !mc_served.
//      mc_start=1, stall=1, bubble_ex=1. Next state MCWAIT, cnt<=0.
//    - Load-use condition: i_ex_valid && i_ex_memread && i_ex_rd!=0, and ex_rd matches
//      a used rs1/rs2. stall=1, bubble_ex=1 for exactly that cycle; state stays RUN.
//   REDIR
//    - kill_if=1 in every REDIR cycle. i_jmp is ignored.
//    - If cnt==0, next state RUN; otherwise cnt decrements.
//   MCWAIT
//    - stall=1 and bubble_ex=1 in every MCWAIT cycle. i_jmp is ignored (EX holds a bubble).
//    - On i_mc_done: next state RUN and mc_served<=1.
//    - Else if cnt==MC_TIMEOUT-1: mc_err<=1, mc_served<=1, next state RUN.
//    - Else cnt increments. If done and timeout coincide, done wins and mc_err is not set.
//   mc_served is cleared on the first RUN cycle with stall==0 (the instruction left ID).
//   This prevents the completed instruction from restarting the unit.
//  Reset
//   - While i_reset=1: stall=0, bubble_ex=1, flush_id=1; all other outputs 0.
//   - On the next edge: state=RUN, cnt=0, mc_served=0, mc_err=0.
//   - Reset mid-REDIR or mid-MCWAIT aborts the operation with no mc_err.
//  o_pc_target is 0 whenever o_pc_load is 0.
// TESTING
//  T1 MEM x5 wr, WB x5 wr, ID rs1=5 -> fwd_a=1; with MEM rd=0 -> fwd_a=2; rs2=0 -> fwd_b=0.
//  T2 EX lw x7, ID add rs2=7 use_rs2=1 -> stall=1 and bubble_ex=1 for 1 cycle, 0 after.
//  T3 i_jmp=1, jmp_pc=0x100 in RUN -> pc_load=1, target=0x100, flush_id=1; kill_if 2 cyc.
//  T4 i_jmp coincides with ID load-use and i_id_mc -> only redirect actions; no mc_start.
//  T5 i_id_mc, i_mc_done after 5 cyc -> mc_start 1 pulse, stall 6 cyc, no restart.
//  T6 i_id_mc, no done -> mc_err=1 after 64 MCWAIT cycles; i_reset mid-MCWAIT -> RUN.

Source files
------------

// File: rtl/ex_pipe_ctrl.sv
// ex_pipe_ctrl: EX-stage sequencer for operand forwarding, load-use and multi-cycle stalls, and fetch redirect.
module ex_pipe_ctrl #(
    parameter int REDIRECT_CYC = 2,
    parameter int MC_TIMEOUT   = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_id_valid,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_use_rs1,
    input  logic        i_id_use_rs2,
    input  logic        i_id_mc,
    input  logic        i_ex_valid,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_memread,
    input  logic        i_jmp,
    input  logic [31:0] i_jmp_pc,
    input  logic [4:0]  i_mem_rd,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_mem_regwrite,
    input  logic        i_wb_regwrite,
    input  logic        i_mc_done,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b,
    output logic        o_stall,
    output logic        o_bubble_ex,
    output logic        o_flush_id,
    output logic        o_pc_load,
    output logic [31:0] o_pc_target,
    output logic        o_kill_if,
    output logic        o_mc_start,
    output logic        o_mc_err,
    output logic [1:0]  o_state
);
    localparam logic [1:0] S_RUN = 2'd0, S_REDIR = 2'd1, S_MCWAIT = 2'd2;
    localparam logic [7:0] REDIR_INIT = 8'(REDIRECT_CYC - 1);
    localparam logic [7:0] MC_LAST    = 8'(MC_TIMEOUT - 1);
    logic [1:0] state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       mc_served, mc_served_nx, mc_err, mc_err_nx;
    logic       run, redir_c, mc_c, lu_c;
    assign run     = state != S_REDIR && state != S_MCWAIT;
    assign redir_c = i_ex_valid && i_jmp;
    assign mc_c    = i_id_valid && i_id_mc && !mc_served;
    assign lu_c    = i_ex_valid && i_ex_memread && i_ex_rd != 5'd0 &&
                     ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) || (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        return (i_mem_regwrite && i_mem_rd != 5'd0 && i_mem_rd == rs) ? 2'd1 :
               (i_wb_regwrite && i_wb_rd != 5'd0 && i_wb_rd == rs)    ? 2'd2 : 2'd0;
    endfunction
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_RUN;
            cnt       <= 8'd0;
            mc_served <= 1'b0;
            mc_err    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mc_served <= mc_served_nx;
            mc_err    <= mc_err_nx;
        end
    end
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        mc_served_nx = mc_served;
        mc_err_nx    = mc_err;
        if (state == S_REDIR) begin
            if (cnt == 8'd0) state_nx = S_RUN;
            else cnt_nx = cnt - 8'd1;
        end else if (state == S_MCWAIT) begin
            if (i_mc_done || cnt == MC_LAST) begin
                state_nx     = S_RUN;
                mc_served_nx = 1'b1;
                mc_err_nx    = mc_err || !i_mc_done;
            end else cnt_nx = cnt + 8'd1;
        end else if (redir_c) begin
            state_nx     = S_REDIR;
            cnt_nx       = REDIR_INIT;
            mc_served_nx = 1'b0;
        end else if (mc_c) begin
            state_nx = S_MCWAIT;
            cnt_nx   = 8'd0;
        end else if (!lu_c) mc_served_nx = 1'b0;
    end
    // Reset forces a bubble and an ID flush so nothing half-decoded leaks out.
    always_comb begin
        o_fwd_a     = i_reset ? 2'd0 : fwd_sel(i_id_rs1);
        o_fwd_b     = i_reset ? 2'd0 : fwd_sel(i_id_rs2);
        o_stall     = !i_reset && (state == S_MCWAIT || (run && !redir_c && (mc_c || lu_c)));
        o_bubble_ex = i_reset || state == S_MCWAIT || (run && (redir_c || mc_c || lu_c));
        o_flush_id  = i_reset || (run && redir_c);
        o_pc_load   = !i_reset && run && redir_c;
        o_pc_target = o_pc_load ? i_jmp_pc : 32'd0;
        o_kill_if   = !i_reset && state == S_REDIR;
        o_mc_start  = !i_reset && run && !redir_c && mc_c;
        o_mc_err    = !i_reset && mc_err;
        o_state     = i_reset ? S_RUN : (run ? S_RUN : state);
    end
endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// tb_ex_pipe_ctrl: directed checks of forwarding, load-use, redirect and multi-cycle control.
module tb_ex_pipe_ctrl;
    logic        i_clk = 0, i_reset = 1;
    logic        i_id_valid = 0, i_id_use_rs1 = 0, i_id_use_rs2 = 0, i_id_mc = 0;
    logic [4:0]  i_id_rs1 = 0, i_id_rs2 = 0, i_ex_rd = 0, i_mem_rd = 0, i_wb_rd = 0;
    logic        i_ex_valid = 0, i_ex_memread = 0, i_jmp = 0;
    logic [31:0] i_jmp_pc = 0;
    logic        i_mem_regwrite = 0, i_wb_regwrite = 0, i_mc_done = 0;
    logic [1:0]  o_fwd_a, o_fwd_b, o_state;
    logic        o_stall, o_bubble_ex, o_flush_id, o_pc_load, o_kill_if, o_mc_start, o_mc_err;
    logic [31:0] o_pc_target;
    int total = 0, bad = 0;
    ex_pipe_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_id_valid(i_id_valid), .i_id_rs1(i_id_rs1),
        .i_id_rs2(i_id_rs2), .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
        .i_id_mc(i_id_mc), .i_ex_valid(i_ex_valid), .i_ex_rd(i_ex_rd), .i_ex_memread(i_ex_memread),
        .i_jmp(i_jmp), .i_jmp_pc(i_jmp_pc), .i_mem_rd(i_mem_rd), .i_wb_rd(i_wb_rd),
        .i_mem_regwrite(i_mem_regwrite), .i_wb_regwrite(i_wb_regwrite), .i_mc_done(i_mc_done),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_stall(o_stall), .o_bubble_ex(o_bubble_ex),
        .o_flush_id(o_flush_id), .o_pc_load(o_pc_load), .o_pc_target(o_pc_target),
        .o_kill_if(o_kill_if), .o_mc_start(o_mc_start), .o_mc_err(o_mc_err), .o_state(o_state)
    );
    always #5 i_clk = ~i_clk;
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic ctl(input string tag, input logic [1:0] st, input logic stall, input logic bub,
                       input logic flush, input logic kill, input logic start);
        chk({tag, ".state"}, 32'(o_state), 32'(st));
        chk({tag, ".stall"}, 32'(o_stall), 32'(stall));
        chk({tag, ".bubble"}, 32'(o_bubble_ex), 32'(bub));
        chk({tag, ".flush"}, 32'(o_flush_id), 32'(flush));
        chk({tag, ".kill"}, 32'(o_kill_if), 32'(kill));
        chk({tag, ".mcstart"}, 32'(o_mc_start), 32'(start));
    endtask
    initial begin
        i_mem_regwrite = 1; i_mem_rd = 5; i_id_rs1 = 5; i_ex_valid = 1; i_jmp = 1; i_jmp_pc = 32'h44;
        tick();
        ctl("rst", 0, 0, 1, 1, 0, 0);
        chk("rst.fwd_a", 32'(o_fwd_a), 0);
        chk("rst.pcload", 32'(o_pc_load), 0);
        chk("rst.err", 32'(o_mc_err), 0);
        i_ex_valid = 0; i_jmp = 0; i_jmp_pc = 0;
        tick();
        i_reset = 0;
        tick();
        ctl("idle", 0, 0, 0, 0, 0, 0);
        // T1 forwarding
        i_wb_regwrite = 1; i_wb_rd = 5; i_id_rs2 = 0;
        #1 chk("t1.mem", 32'(o_fwd_a), 1);
        chk("t1.b_x0", 32'(o_fwd_b), 0);
        i_mem_rd = 0;
        #1 chk("t1.wb", 32'(o_fwd_a), 2);
        i_id_rs2 = 5; i_mem_rd = 5; i_mem_regwrite = 0;
        #1 chk("t1.b_wb", 32'(o_fwd_b), 2);
        i_wb_regwrite = 0;
        #1 chk("t1.none", 32'(o_fwd_a), 0);
        i_mem_rd = 0; i_wb_rd = 0; i_id_rs1 = 0; i_id_rs2 = 0;
        // T2 load-use
        i_id_valid = 1; i_id_rs2 = 7; i_id_use_rs2 = 0; i_ex_valid = 1; i_ex_memread = 1; i_ex_rd = 7;
        #1 ctl("t2.unused", 0, 0, 0, 0, 0, 0);
        i_id_use_rs2 = 1;
        #1 ctl("t2.hit", 0, 1, 1, 0, 0, 0);
        tick();
        i_ex_valid = 0;
        #1 ctl("t2.after", 0, 0, 0, 0, 0, 0);
        i_ex_valid = 1; i_ex_rd = 0; i_id_rs2 = 0;
        #1 chk("t2.x0", 32'(o_stall), 0);
        i_ex_memread = 0; i_id_use_rs2 = 0; i_id_valid = 0;
        // T3 redirect
        i_jmp = 1; i_jmp_pc = 32'h100;
        #1 ctl("t3.jmp", 0, 0, 1, 1, 0, 0);
        chk("t3.load", 32'(o_pc_load), 1);
        chk("t3.tgt", o_pc_target, 32'h100);
        tick();
        i_jmp_pc = 32'h200;
        #1 ctl("t3.r1", 1, 0, 0, 0, 1, 0);
        chk("t3.r1load", 32'(o_pc_load), 0);
        chk("t3.r1tgt", o_pc_target, 0);
        tick();
        ctl("t3.r2", 1, 0, 0, 0, 1, 0);
        i_jmp = 0; i_ex_valid = 0;
        tick();
        ctl("t3.done", 0, 0, 0, 0, 0, 0);
        // T4 redirect beats multi-cycle and load-use
        i_ex_valid = 1; i_jmp = 1; i_jmp_pc = 32'h40; i_ex_memread = 1; i_ex_rd = 7;
        i_id_valid = 1; i_id_rs2 = 7; i_id_use_rs2 = 1; i_id_mc = 1;
        #1 ctl("t4", 0, 0, 1, 1, 0, 0);
        chk("t4.tgt", o_pc_target, 32'h40);
        tick();
        i_ex_valid = 0; i_jmp = 0; i_ex_memread = 0; i_id_mc = 0; i_id_valid = 0; i_id_use_rs2 = 0;
        tick();
        tick();
        ctl("t4.back", 0, 0, 0, 0, 0, 0);
        // T5 multi-cycle with done on the 5th wait cycle
        i_id_valid = 1; i_id_mc = 1;
        #1 ctl("t5.start", 0, 1, 1, 0, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 5) i_mc_done = 1;
            #1 ctl($sformatf("t5.w%0d", i), 2, 1, 1, 0, 0, 0);
        end
        tick();
        i_mc_done = 0;
        #1 ctl("t5.norestart", 0, 0, 0, 0, 0, 0);
        chk("t5.err", 32'(o_mc_err), 0);
        i_id_mc = 0; i_id_valid = 0;
        tick();
        // T6 timeout
        i_id_valid = 1; i_id_mc = 1;
        tick();
        for (int i = 0; i < 63; i++) tick();
        ctl("t6.last", 2, 1, 1, 0, 0, 0);
        chk("t6.noerr", 32'(o_mc_err), 0);
        tick();
        ctl("t6.out", 0, 0, 0, 0, 0, 0);
        chk("t6.err", 32'(o_mc_err), 1);
        i_id_mc = 0; i_id_valid = 0;
        tick();
        chk("t6.sticky", 32'(o_mc_err), 1);
        // reset during MCWAIT
        i_id_valid = 1; i_id_mc = 1;
        tick();
        tick();
        chk("t6.wait", 32'(o_state), 2);
        i_reset = 1;
        #1 ctl("t6.rst", 0, 0, 1, 1, 0, 0);
        tick();
        i_reset = 0; i_id_mc = 0; i_id_valid = 0;
        #1 ctl("t6.rstd", 0, 0, 0, 0, 0, 0);
        chk("t6.rsterr", 32'(o_mc_err), 0);
        // done and timeout in the same cycle: done wins
        i_id_valid = 1; i_id_mc = 1;
        tick();
        for (int i = 0; i < 63; i++) tick();
        i_mc_done = 1;
        tick();
        i_mc_done = 0; i_id_mc = 0; i_id_valid = 0;
        #1 chk("tie.state", 32'(o_state), 0);
        chk("tie.err", 32'(o_mc_err), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
